chess_clock_timer: RTL and testbench

//  Per-player countdown timer driven by the chess clock control FSM; one instance per player.

---
 rtl/chess_clock_timer.sv | 149 ++++++++++++++
 tb/tb_chess_clock_timer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/chess_clock_timer.sv
// rtl/chess_clock_timer.sv - per-player BCD mm:ss countdown with optional Fischer increment
module chess_clock_timer #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int START_MIN = 5,
  parameter int START_SEC = 0,
  parameter int INC_SEC   = 0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_restart,
  input  logic       i_stop,
  output logic       o_zero,
  output logic       o_running,
  output logic [3:0] o_min_tens,
  output logic [3:0] o_min_ones,
  output logic [3:0] o_sec_tens,
  output logic [3:0] o_sec_ones
);

  localparam int             PW       = $clog2(CLK_HZ);
  localparam logic [PW-1:0]  PS_MAX   = PW'(CLK_HZ - 1);
  localparam logic [3:0]     START_MT = 4'(START_MIN / 10);
  localparam logic [3:0]     START_MO = 4'(START_MIN % 10);
  localparam logic [3:0]     START_ST = 4'(START_SEC / 10);
  localparam logic [3:0]     START_SO = 4'(START_SEC % 10);
  localparam logic [7:0]     INC      = 8'(INC_SEC);

  typedef enum logic [1:0] {HOLD = 2'd0, RUN = 2'd1, EXPIRED = 2'd2} state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic [3:0]    min_t, min_o, sec_t, sec_o;
  logic          zero, running;

  logic          wrap, time_zero, dec_zero, reload;
  logic [3:0]    dec_mt, dec_mo, dec_st, dec_so;
  logic [3:0]    inc_mt, inc_mo, inc_st, inc_so;
  logic [7:0]    sec_sum, min_sum;

  assign wrap      = (presc >= PS_MAX);
  assign time_zero = ({min_t, min_o, sec_t, sec_o} == 16'h0000);
  assign dec_zero  = ({dec_mt, dec_mo, dec_st, dec_so} == 16'h0000);
  assign reload    = i_rst || i_restart || !(state inside {HOLD, RUN, EXPIRED});

  // One-second BCD decrement with borrow chain; only applied while time is nonzero.
  always_comb begin
    dec_mt = min_t;
    dec_mo = min_o;
    dec_st = sec_t;
    dec_so = sec_o;
    if (sec_o != 4'd0) begin
      dec_so = sec_o - 4'd1;
    end else begin
      dec_so = 4'd9;
      if (sec_t != 4'd0) begin
        dec_st = sec_t - 4'd1;
      end else begin
        dec_st = 4'd5;
        if (min_o != 4'd0) begin
          dec_mo = min_o - 4'd1;
        end else begin
          dec_mo = 4'd9;
          dec_mt = min_t - 4'd1;
        end
      end
    end
  end

  // Fischer increment in binary, saturating at 99:59, then back to BCD.
  always_comb begin
    sec_sum = {4'd0, sec_t} * 8'd10 + {4'd0, sec_o} + INC;
    min_sum = {4'd0, min_t} * 8'd10 + {4'd0, min_o};
    if (sec_sum >= 8'd60) begin
      sec_sum = sec_sum - 8'd60;
      min_sum = min_sum + 8'd1;
    end
    if (min_sum > 8'd99) begin
      min_sum = 8'd99;
      sec_sum = 8'd59;
    end
    inc_mt = 4'(min_sum / 8'd10);
    inc_mo = 4'(min_sum % 8'd10);
    inc_st = 4'(sec_sum / 8'd10);
    inc_so = 4'(sec_sum % 8'd10);
  end

  always_ff @(posedge i_clk) begin
    if (reload) begin
      state   <= HOLD;
      presc   <= '0;
      min_t   <= START_MT;
      min_o   <= START_MO;
      sec_t   <= START_ST;
      sec_o   <= START_SO;
      zero    <= 1'b0;
      running <= 1'b0;
    end else begin
      case (state)
        HOLD: begin
          if (!i_stop) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          if (time_zero) begin
            state   <= EXPIRED;
            zero    <= 1'b1;
            running <= 1'b0;
          end else begin
            presc <= wrap ? '0 : presc + 1'b1;
            // A tick landing on the stop edge is dropped in favour of the increment.
            if (i_stop) begin
              state   <= HOLD;
              running <= 1'b0;
              min_t   <= inc_mt;
              min_o   <= inc_mo;
              sec_t   <= inc_st;
              sec_o   <= inc_so;
            end else if (wrap) begin
              min_t <= dec_mt;
              min_o <= dec_mo;
              sec_t <= dec_st;
              sec_o <= dec_so;
              if (dec_zero) begin
                state   <= EXPIRED;
                zero    <= 1'b1;
                running <= 1'b0;
              end
            end
          end
        end
        EXPIRED: begin
          zero    <= 1'b1;
          running <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign o_zero     = zero;
  assign o_running  = running;
  assign o_min_tens = min_t;
  assign o_min_ones = min_o;
  assign o_sec_tens = sec_t;
  assign o_sec_ones = sec_o;

endmodule

// File: tb/tb_chess_clock_timer.sv
// tb/tb_chess_clock_timer.sv - directed bench for chess_clock_timer with CLK_HZ=10
module tb_chess_clock_timer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rs_a = 0, rs_b = 0, rs_c = 0, rs_d = 0, rs_e = 0;
  logic st_a = 1, st_b = 1, st_c = 1, st_d = 1, st_e = 1;
  wire  z_a, z_b, z_c, z_d, z_e;
  wire  r_a, r_b, r_c, r_d, r_e;
  wire [15:0] t_a, t_b, t_c, t_d, t_e;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  chess_clock_timer #(.CLK_HZ(10), .START_MIN(5), .START_SEC(0), .INC_SEC(0)) u_a (
    .i_clk(clk), .i_rst(rst), .i_restart(rs_a), .i_stop(st_a), .o_zero(z_a), .o_running(r_a),
    .o_min_tens(t_a[15:12]), .o_min_ones(t_a[11:8]), .o_sec_tens(t_a[7:4]), .o_sec_ones(t_a[3:0]));
  chess_clock_timer #(.CLK_HZ(10), .START_MIN(1), .START_SEC(0), .INC_SEC(0)) u_b (
    .i_clk(clk), .i_rst(rst), .i_restart(rs_b), .i_stop(st_b), .o_zero(z_b), .o_running(r_b),
    .o_min_tens(t_b[15:12]), .o_min_ones(t_b[11:8]), .o_sec_tens(t_b[7:4]), .o_sec_ones(t_b[3:0]));
  chess_clock_timer #(.CLK_HZ(10), .START_MIN(5), .START_SEC(0), .INC_SEC(5)) u_c (
    .i_clk(clk), .i_rst(rst), .i_restart(rs_c), .i_stop(st_c), .o_zero(z_c), .o_running(r_c),
    .o_min_tens(t_c[15:12]), .o_min_ones(t_c[11:8]), .o_sec_tens(t_c[7:4]), .o_sec_ones(t_c[3:0]));
  chess_clock_timer #(.CLK_HZ(10), .START_MIN(0), .START_SEC(59), .INC_SEC(5)) u_d (
    .i_clk(clk), .i_rst(rst), .i_restart(rs_d), .i_stop(st_d), .o_zero(z_d), .o_running(r_d),
    .o_min_tens(t_d[15:12]), .o_min_ones(t_d[11:8]), .o_sec_tens(t_d[7:4]), .o_sec_ones(t_d[3:0]));
  chess_clock_timer #(.CLK_HZ(10), .START_MIN(99), .START_SEC(58), .INC_SEC(5)) u_e (
    .i_clk(clk), .i_rst(rst), .i_restart(rs_e), .i_stop(st_e), .o_zero(z_e), .o_running(r_e),
    .o_min_tens(t_e[15:12]), .o_min_ones(t_e[11:8]), .o_sec_tens(t_e[7:4]), .o_sec_ones(t_e[3:0]));

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
    total++; if (t_a !== 16'h0500) $display("FAIL reset_time got %h want 0500", t_a); else passed++;
    total++; if (z_a !== 1'b0) $display("FAIL reset_zero got %b want 0", z_a); else passed++;
    total++; if (r_a !== 1'b0) $display("FAIL reset_running got %b want 0", r_a); else passed++;
    total++; if (t_e !== 16'h9958) $display("FAIL reset_time_e got %h want 9958", t_e); else passed++;
    step(100);
    total++; if (t_a !== 16'h0500) $display("FAIL hold_100 got %h want 0500", t_a); else passed++;
    total++; if (r_a !== 1'b0) $display("FAIL hold_running got %b want 0", r_a); else passed++;
  endtask

  task automatic test_run;
    st_a = 1'b0;
    step(1);
    total++; if (r_a !== 1'b1) $display("FAIL run_enter got %b want 1", r_a); else passed++;
    step(9);
    total++; if (t_a !== 16'h0500) $display("FAIL run_9cyc got %h want 0500", t_a); else passed++;
    step(1);
    total++; if (t_a !== 16'h0459) $display("FAIL run_10cyc got %h want 0459", t_a); else passed++;
    step(10);
    total++; if (t_a !== 16'h0458) $display("FAIL run_20cyc got %h want 0458", t_a); else passed++;
  endtask

  task automatic test_resume_fraction;
    // prescaler is 0 here; six run cycles plus the stop edge leave it at 7
    step(6);
    st_a = 1'b1;
    step(1);
    total++; if (r_a !== 1'b0) $display("FAIL frac_stop_running got %b want 0", r_a); else passed++;
    step(50);
    total++; if (t_a !== 16'h0458) $display("FAIL frac_hold got %h want 0458", t_a); else passed++;
    st_a = 1'b0;
    step(1);
    step(2);
    total++; if (t_a !== 16'h0458) $display("FAIL frac_2cyc got %h want 0458", t_a); else passed++;
    step(1);
    total++; if (t_a !== 16'h0457) $display("FAIL frac_3cyc got %h want 0457", t_a); else passed++;
  endtask

  task automatic test_restart;
    step(1000);
    total++; if (t_a !== 16'h0317) $display("FAIL restart_pre got %h want 0317", t_a); else passed++;
    rs_a = 1'b1;
    step(1);
    total++; if (t_a !== 16'h0500) $display("FAIL restart_time got %h want 0500", t_a); else passed++;
    total++; if (r_a !== 1'b0) $display("FAIL restart_running got %b want 0", r_a); else passed++;
    step(5);
    total++; if (t_a !== 16'h0500 || r_a !== 1'b0)
      $display("FAIL restart_held got %h/%b want 0500/0", t_a, r_a); else passed++;
    rs_a = 1'b0;
    step(1);
    total++; if (r_a !== 1'b1) $display("FAIL restart_resume got %b want 1", r_a); else passed++;
    step(9);
    total++; if (t_a !== 16'h0500) $display("FAIL restart_9cyc got %h want 0500", t_a); else passed++;
    step(1);
    total++; if (t_a !== 16'h0459) $display("FAIL restart_10cyc got %h want 0459", t_a); else passed++;
  endtask

  task automatic test_expire;
    st_b = 1'b0;
    step(1);
    step(10);
    total++; if (t_b !== 16'h0059) $display("FAIL exp_59 got %h want 0059", t_b); else passed++;
    step(90);
    total++; if (t_b !== 16'h0050) $display("FAIL exp_50 got %h want 0050", t_b); else passed++;
    step(400);
    total++; if (t_b !== 16'h0010) $display("FAIL exp_10 got %h want 0010", t_b); else passed++;
    step(10);
    total++; if (t_b !== 16'h0009) $display("FAIL exp_09 got %h want 0009", t_b); else passed++;
    step(89);
    total++; if (t_b !== 16'h0001 || z_b !== 1'b0)
      $display("FAIL exp_599 got %h/%b want 0001/0", t_b, z_b); else passed++;
    step(1);
    total++; if (t_b !== 16'h0000 || z_b !== 1'b1 || r_b !== 1'b0)
      $display("FAIL exp_600 got %h/%b/%b want 0000/1/0", t_b, z_b, r_b); else passed++;
    st_b = 1'b1;
    step(3);
    st_b = 1'b0;
    step(3);
    total++; if (t_b !== 16'h0000 || z_b !== 1'b1)
      $display("FAIL exp_toggle got %h/%b want 0000/1", t_b, z_b); else passed++;
    rs_b = 1'b1;
    step(1);
    total++; if (t_b !== 16'h0100 || z_b !== 1'b0 || r_b !== 1'b0)
      $display("FAIL exp_restart got %h/%b/%b want 0100/0/0", t_b, z_b, r_b); else passed++;
    rs_b = 1'b0;
    step(1);
    total++; if (r_b !== 1'b1) $display("FAIL exp_rerun got %b want 1", r_b); else passed++;
  endtask

  task automatic test_increment;
    st_c = 1'b0;
    step(1);
    step(20);
    total++; if (t_c !== 16'h0458) $display("FAIL inc_pre got %h want 0458", t_c); else passed++;
    st_c = 1'b1;
    step(1);
    total++; if (t_c !== 16'h0503 || r_c !== 1'b0)
      $display("FAIL inc_0458 got %h/%b want 0503/0", t_c, r_c); else passed++;
    // prescaler now 1; resume and stop exactly on the tick edge
    st_c = 1'b0;
    step(1);
    step(8);
    st_c = 1'b1;
    step(1);
    total++; if (t_c !== 16'h0508) $display("FAIL inc_tick_discard got %h want 0508", t_c); else passed++;
    st_d = 1'b0;
    step(1);
    step(20);
    st_d = 1'b1;
    step(1);
    total++; if (t_d !== 16'h0102) $display("FAIL inc_0057 got %h want 0102", t_d); else passed++;
    st_e = 1'b0;
    step(1);
    step(3);
    st_e = 1'b1;
    step(1);
    total++; if (t_e !== 16'h9959) $display("FAIL inc_saturate got %h want 9959", t_e); else passed++;
  endtask

  initial begin
    test_reset;
    test_run;
    test_resume_fraction;
    test_restart;
    test_expire;
    test_increment;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
